// File: rtl/cpu_types_pkg.sv
// Shared CPU-side types: bus word, RAM handshake state and the memory-controller FSM states.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {FREE, BUSY, ACCESS, ERROR} ramstate_t;

  typedef enum logic [2:0] {IDLE, WB, SNOOP, C2C, RAMRD, IFETCH} memctl_state_t;

endpackage

// File: rtl/cache_control_if.sv
// Bundle between the per-core caches, the coherence bus controller and the RAM model.
interface cache_control_if #(
  parameter int unsigned CPUS = 2
) ();

  logic [CPUS-1:0] iREN, dREN, dWEN, ccwrite, cctrans;
  logic [CPUS-1:0] iwait, dwait, ccwait, ccinv;
  cpu_types_pkg::word_t [CPUS-1:0] iaddr, daddr, dstore;
  cpu_types_pkg::word_t [CPUS-1:0] iload, dload, ccsnoopaddr;
  cpu_types_pkg::word_t ramload, ramaddr, ramstore;
  cpu_types_pkg::ramstate_t ramstate;
  logic ramREN, ramWEN;

  modport cc (
    input  iREN, dREN, dWEN, iaddr, daddr, dstore, ccwrite, cctrans, ramload, ramstate,
    output iwait, dwait, iload, dload, ccwait, ccinv, ccsnoopaddr,
    output ramaddr, ramstore, ramREN, ramWEN
  );

endinterface

// File: rtl/bus_arbiter.sv
// Combinational pick of the next bus transaction: class priority writeback > dread > ifetch,
// and within a class the round-robin preferred core wins.
module bus_arbiter import cpu_types_pkg::*; #(
  parameter int unsigned CPUS = 2
) (
  input  logic [CPUS-1:0] iren,
  input  logic [CPUS-1:0] dren,
  input  logic [CPUS-1:0] dwen,
  input  logic [CPUS-1:0] cctrans,
  input  logic            rr,
  output logic            g,
  output memctl_state_t   kind,
  output logic            valid
);

  // dWEN with cctrans is a snoop flush answer, never a writeback request.
  logic [CPUS-1:0] wb;
  assign wb = dwen & ~cctrans;

  always_comb begin
    g     = rr;
    kind  = IDLE;
    valid = 1'b1;
    if (|wb) begin
      kind = WB;
      g    = wb[rr] ? rr : ~rr;
    end else if (|dren) begin
      kind = SNOOP;
      g    = dren[rr] ? rr : ~rr;
    end else if (|iren) begin
      kind = IFETCH;
      g    = iren[rr] ? rr : ~rr;
    end else begin
      valid = 1'b0;
    end
  end

endmodule

// File: rtl/coherence_memory_control.sv
// MSI bus controller: arbitrates icache/dcache words onto one RAM port and runs the snoop
// phase (invalidate, cache-to-cache forwarding of Modified data) against the other core.
module coherence_memory_control import cpu_types_pkg::*; #(
  parameter int unsigned CPUS    = 2,
  parameter int unsigned RR_INIT = 0
) (
  input logic         CLK,
  input logic         RST,
  cache_control_if.cc ccif
);

  memctl_state_t state, arb_kind;
  logic rr, g, o, arb_g, arb_valid, access;

  logic [CPUS-1:0] iwait, dwait, ccwait, ccinv;
  word_t [CPUS-1:0] iload, dload, snoopaddr;
  word_t ramaddr, ramstore;
  logic ramren, ramwen;

  assign o      = ~g;
  assign access = (ccif.ramstate == ACCESS);

  bus_arbiter #(.CPUS(CPUS)) u_arb (
    .iren    (ccif.iREN),
    .dren    (ccif.dREN),
    .dwen    (ccif.dWEN),
    .cctrans (ccif.cctrans),
    .rr      (rr),
    .g       (arb_g),
    .kind    (arb_kind),
    .valid   (arb_valid)
  );

  // BUSY and ERROR both leave the state untouched, so the word is simply retried.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= IDLE;
      rr    <= (RR_INIT != 0);
      g     <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (arb_valid) begin
            state <= arb_kind;
            g     <= arb_g;
          end
        end
        WB: begin
          if (!ccif.dWEN[g]) begin
            state <= IDLE;
          end else if (access) begin
            state <= IDLE;
            rr    <= ~rr;
          end
        end
        SNOOP: begin
          if (!ccif.dREN[g])                       state <= IDLE;
          else if (ccif.dWEN[o] && ccif.cctrans[o]) state <= C2C;
          else                                      state <= RAMRD;
        end
        C2C, RAMRD: begin
          if (!ccif.dREN[g]) begin
            state <= IDLE;
          end else if (access) begin
            state <= IDLE;
            rr    <= ~rr;
          end
        end
        IFETCH: begin
          if (!ccif.iREN[g] || access) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    iwait     = '1;
    dwait     = '1;
    iload     = '0;
    dload     = '0;
    ccwait    = '0;
    ccinv     = '0;
    snoopaddr = '0;
    ramaddr   = '0;
    ramstore  = '0;
    ramren    = 1'b0;
    ramwen    = 1'b0;

    // The other core stays frozen from the snoop until the requester's word is done.
    if (state == SNOOP || state == C2C || state == RAMRD) begin
      ccwait[o]    = 1'b1;
      snoopaddr[o] = ccif.daddr[g];
      ccinv[o]     = ccif.ccwrite[g];
    end

    unique case (state)
      WB: begin
        ramwen   = 1'b1;
        ramaddr  = ccif.daddr[g];
        ramstore = ccif.dstore[g];
        if (access && ccif.dWEN[g]) dwait[g] = 1'b0;
      end
      C2C: begin
        dload[g] = ccif.dstore[o];
        ramwen   = 1'b1;
        ramaddr  = ccif.daddr[o];
        ramstore = ccif.dstore[o];
        if (access && ccif.dREN[g]) begin
          dwait[g] = 1'b0;
          dwait[o] = 1'b0;
        end
      end
      RAMRD: begin
        ramren  = 1'b1;
        ramaddr = ccif.daddr[g];
        if (access && ccif.dREN[g]) begin
          dload[g] = ccif.ramload;
          dwait[g] = 1'b0;
        end
      end
      IFETCH: begin
        ramren  = 1'b1;
        ramaddr = ccif.iaddr[g];
        if (access && ccif.iREN[g]) begin
          iload[g] = ccif.ramload;
          iwait[g] = 1'b0;
        end
      end
      default: ;
    endcase
  end

  assign ccif.iwait       = iwait;
  assign ccif.dwait       = dwait;
  assign ccif.iload       = iload;
  assign ccif.dload       = dload;
  assign ccif.ccwait      = ccwait;
  assign ccif.ccinv       = ccinv;
  assign ccif.ccsnoopaddr = snoopaddr;
  assign ccif.ramaddr     = ramaddr;
  assign ccif.ramstore    = ramstore;
  assign ccif.ramREN      = ramren;
  assign ccif.ramWEN      = ramwen;

endmodule
